// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// byte-lane geometry of the 32-bit data-RAM word.
package lsu_pkg;

   localparam int XLEN   = 32;
   localparam int LANE_W = 8;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_X = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: alignment check on the incoming request,
// little-endian lane extraction with sign/zero extension for loads, and the
// read-modify-write merge of a sub-word store into the old RAM word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]      chk_size,
   input  logic [1:0]      chk_lo,
   output logic            chk_misaligned,
   input  logic [1:0]      acc_size,
   input  logic [1:0]      acc_lo,
   input  logic            acc_unsigned,
   input  logic [XLEN-1:0] ld_word,
   output logic [XLEN-1:0] ld_data,
   input  logic [XLEN-1:0] st_old,
   input  logic [XLEN-1:0] st_wdata,
   output logic [XLEN-1:0] st_merged
);

   logic [LANE_W-1:0]   lane_b;
   logic [2*LANE_W-1:0] lane_h;

   // Illegal size, odd halfword or non-word-aligned word is rejected.
   always_comb begin
      chk_misaligned = 1'b0;
      case (chk_size)
         SIZE_H:  chk_misaligned = chk_lo[0];
         SIZE_W:  chk_misaligned = (chk_lo != 2'b00);
         SIZE_X:  chk_misaligned = 1'b1;
         default: chk_misaligned = 1'b0;
      endcase
   end

   // Select the addressed lane and extend it to a full word.
   always_comb begin
      case (acc_lo)
         2'd1:    lane_b = ld_word[15:8];
         2'd2:    lane_b = ld_word[23:16];
         2'd3:    lane_b = ld_word[31:24];
         default: lane_b = ld_word[7:0];
      endcase
      lane_h = acc_lo[1] ? ld_word[31:16] : ld_word[15:0];
      ld_data = ld_word;
      case (acc_size)
         SIZE_B:  ld_data = acc_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
         SIZE_H:  ld_data = acc_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: ld_data = ld_word;
      endcase
   end

   // Replace only the addressed lane(s) of the old word with store data.
   always_comb begin
      st_merged = st_old;
      case (acc_size)
         SIZE_B: begin
            for (int k = 0; k < 4; k++) begin
               if (acc_lo == 2'(k)) st_merged[k*LANE_W +: LANE_W] = st_wdata[LANE_W-1:0];
            end
         end
         SIZE_H: begin
            if (acc_lo[1]) st_merged[31:16] = st_wdata[15:0];
            else           st_merged[15:0]  = st_wdata[15:0];
         end
         SIZE_W:  st_merged = st_wdata;
         default: st_merged = st_old;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request at a time from execute, rejects
// misaligned/illegal accesses, drives the word-addressed data-RAM port and
// returns a one-cycle response. Sub-word stores are read-modify-write.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE, so req_valid while busy is simply ignored.
// rsp_valid is a single-cycle pulse with no back-pressure.
module lsu
   import lsu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   output logic            rsp_err,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   state_t          state_q, state_d;
   logic            we_q, we_d;
   logic [1:0]      size_q, size_d;
   logic            uns_q, uns_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] old_q, old_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;

   logic            accept;
   logic            misaligned;
   logic [XLEN-1:0] ld_data;
   logic [XLEN-1:0] merged;

   assign accept = req_valid && (state_q == ST_IDLE);

   lsu_align u_align (
      .chk_size       (req_size),
      .chk_lo         (req_addr[1:0]),
      .chk_misaligned (misaligned),
      .acc_size       (size_q),
      .acc_lo         (addr_q[1:0]),
      .acc_unsigned   (uns_q),
      .ld_word        (mem_rdata),
      .ld_data        (ld_data),
      .st_old         (old_q),
      .st_wdata       (wdata_q),
      .st_merged      (merged)
   );

   // State register; reset forces IDLE at once, killing any pending write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next state: errors skip memory, word stores skip the read.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (misaligned)                     state_d = ST_RESP;
               else if (req_we && req_size == SIZE_W) state_d = ST_WRITE;
               else                                state_d = ST_READ;
            end
         end
         ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
         ST_WRITE: state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; write data is only driven while writing.
   always_comb begin
      req_ready = (state_q == ST_IDLE);
      rsp_valid = (state_q == ST_RESP);
      rsp_err   = (state_q == ST_RESP) && err_q;
      rsp_rdata = rsp_rdata_q;
      mem_we    = (state_q == ST_WRITE);
      mem_addr  = {addr_q[XLEN-1:2], 2'b00};
      mem_wdata = (state_q == ST_WRITE) ? merged : '0;
   end

   // Request latch, old-word capture and response data computation.
   always_comb begin
      we_d        = we_q;
      size_d      = size_q;
      uns_d       = uns_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      old_d       = old_q;
      err_d       = err_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               err_d   = misaligned;
               if (misaligned) rsp_rdata_d = '0;
            end
         end
         ST_READ: begin
            old_d = mem_rdata;
            if (!we_q) rsp_rdata_d = ld_data;
         end
         ST_WRITE: rsp_rdata_d = '0;
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q        <= 1'b0;
         size_q      <= SIZE_B;
         uns_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         old_q       <= '0;
         err_q       <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         we_q        <= we_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         old_q       <= old_d;
         err_q       <= err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: small word RAM model on the memory port, directed cases and
// randomized requests checked against an arithmetic reference of the RAM.
module tb_lsu;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks;
   int failures;

   logic [31:0] ram     [0:15];
   logic [31:0] ref_mem [0:15];

   // observations recorded by do_req
   logic        o_acc_ready;
   int          o_rd_cyc, o_we_cnt, o_we_cyc, o_rsp_cnt, o_rsp_cyc;
   logic [31:0] o_we_data, o_we_addr, o_rdata, o_held;
   logic        o_err;

   lsu dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_err      (rsp_err),
      .rsp_rdata    (rsp_rdata),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM: combinational read, write on the clock edge
   assign mem_rdata = ram[mem_addr[5:2]];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[5:2]] <= mem_wdata;
   end

   // ---------------- reference model ----------------
   function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] sz,
                                            input logic u, input logic [31:0] a);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (w >> (8 * (a % 4))) & 32'hFF;
         if (!u && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         if (!u && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   function automatic logic [31:0] exp_store(input logic [31:0] old, input logic [1:0] sz,
                                             input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] m;
      int sh;
      if (sz == 2'd0) begin
         sh = 8 * int'(a % 4);
         m = 32'hFF << sh;
         return (old & ~m) | ((wd & 32'hFF) << sh);
      end else if (sz == 2'd1) begin
         sh = 16 * int'((a / 2) % 2);
         m = 32'hFFFF << sh;
         return (old & ~m) | ((wd & 32'hFFFF) << sh);
      end
      return wd;
   endfunction

   // ---------------- driver ----------------
   task automatic do_req(input logic we, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
      req_addr = a; req_wdata = wd;
      o_acc_ready = req_ready;
      @(posedge clk);
      #1 req_valid = 1'b0;
      o_rd_cyc = 0; o_we_cnt = 0; o_we_cyc = 0; o_rsp_cnt = 0; o_rsp_cyc = 0;
      o_we_data = '0; o_we_addr = '0; o_rdata = '0; o_err = 1'b0; o_held = 'x;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (mem_we) begin
            o_we_cnt++; o_we_cyc = c; o_we_data = mem_wdata; o_we_addr = mem_addr;
         end
         if (!req_ready && !mem_we && !rsp_valid && o_rd_cyc == 0) o_rd_cyc = c;
         if (rsp_valid) begin
            o_rsp_cnt++;
            if (o_rsp_cyc == 0) begin
               o_rsp_cyc = c; o_err = rsp_err; o_rdata = rsp_rdata;
            end
         end
         if (req_ready) begin
            o_held = rsp_rdata;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h1234_5678;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
      checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
      checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got %h exp 0", rsp_rdata); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
      req_valid = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL reset_no_accept got valid=%b ready=%b exp 0/1", rsp_valid, req_ready); end
      checks++; if (ram[0] !== ref_mem[0]) begin failures++; $display("FAIL reset_ram got %h exp %h", ram[0], ref_mem[0]); end
   endtask

   task automatic test_loads;
      logic [31:0] exp_v [3];
      logic [1:0]  szs   [3];
      logic        us    [3];
      logic [31:0] as    [3];
      exp_v[0] = 32'hFFFF_FF88; szs[0] = 2'd0; us[0] = 1'b0; as[0] = 32'h7;
      exp_v[1] = 32'h0000_0088; szs[1] = 2'd0; us[1] = 1'b1; as[1] = 32'h7;
      exp_v[2] = 32'hFFFF_8877; szs[2] = 2'd1; us[2] = 1'b0; as[2] = 32'h6;
      for (int i = 0; i < 3; i++) begin
         do_req(1'b0, szs[i], us[i], as[i], 32'h0);
         checks++; if (o_rdata !== exp_v[i]) begin failures++; $display("FAIL load_data[%0d] got %h exp %h", i, o_rdata, exp_v[i]); end
         checks++; if (o_rsp_cyc != 2 || o_rd_cyc != 1) begin failures++; $display("FAIL load_timing[%0d] got rsp=%0d rd=%0d exp 2/1", i, o_rsp_cyc, o_rd_cyc); end
         checks++; if (o_we_cnt != 0 || o_err !== 1'b0) begin failures++; $display("FAIL load_side[%0d] got we=%0d err=%b exp 0/0", i, o_we_cnt, o_err); end
      end
   endtask

   task automatic test_subword_store;
      do_req(1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_00AB);
      ref_mem[1] = 32'h8877_AB55;
      checks++; if (o_rd_cyc != 1) begin failures++; $display("FAIL sb_read_cyc got %0d exp 1", o_rd_cyc); end
      checks++; if (o_we_cnt != 1 || o_we_cyc != 2) begin failures++; $display("FAIL sb_we got cnt=%0d cyc=%0d exp 1/2", o_we_cnt, o_we_cyc); end
      checks++; if (o_we_data !== 32'h8877_AB55) begin failures++; $display("FAIL sb_wdata got %h exp 8877ab55", o_we_data); end
      checks++; if (o_we_addr !== 32'h4) begin failures++; $display("FAIL sb_addr got %h exp 4", o_we_addr); end
      checks++; if (o_rsp_cyc != 3 || o_rdata !== 32'h0) begin failures++; $display("FAIL sb_rsp got cyc=%0d data=%h exp 3/0", o_rsp_cyc, o_rdata); end
      do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
      checks++; if (o_rdata !== 32'h8877_AB55) begin failures++; $display("FAIL sb_readback got %h exp 8877ab55", o_rdata); end
   endtask

   task automatic test_word_store;
      do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEAD_BEEF);
      ref_mem[2] = 32'hDEAD_BEEF;
      checks++; if (o_we_cnt != 1 || o_we_cyc != 1) begin failures++; $display("FAIL sw_we got cnt=%0d cyc=%0d exp 1/1", o_we_cnt, o_we_cyc); end
      checks++; if (o_we_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_wdata got %h exp deadbeef", o_we_data); end
      checks++; if (o_rsp_cyc != 2) begin failures++; $display("FAIL sw_rsp_cyc got %0d exp 2", o_rsp_cyc); end
      checks++; if (ram[2] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sw_ram got %h exp deadbeef", ram[2]); end
   endtask

   task automatic test_errors;
      logic        wes [3];
      logic [1:0]  szs [3];
      logic [31:0] as  [3];
      wes[0] = 1'b0; szs[0] = 2'd1; as[0] = 32'h3;
      wes[1] = 1'b1; szs[1] = 2'd2; as[1] = 32'h6;
      wes[2] = 1'b1; szs[2] = 2'd3; as[2] = 32'hC;
      for (int i = 0; i < 3; i++) begin
         do_req(wes[i], szs[i], 1'b0, as[i], 32'hCAFE_F00D);
         checks++; if (o_err !== 1'b1 || o_rsp_cyc != 1) begin failures++; $display("FAIL err_rsp[%0d] got err=%b cyc=%0d exp 1/1", i, o_err, o_rsp_cyc); end
         checks++; if (o_we_cnt != 0 || o_rdata !== 32'h0) begin failures++; $display("FAIL err_side[%0d] got we=%0d data=%h exp 0/0", i, o_we_cnt, o_rdata); end
         checks++; if (ram[as[i][5:2]] !== ref_mem[as[i][5:2]]) begin failures++; $display("FAIL err_ram[%0d] got %h exp %h", i, ram[as[i][5:2]], ref_mem[as[i][5:2]]); end
      end
   endtask

   task automatic test_reset_mid;
      int n_we, n_rsp;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h5; req_wdata = 32'h0000_0011;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL mid_in_read got ready=%b we=%b exp 0/0", req_ready, mem_we); end
      rst = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL mid_async got ready=%b we=%b exp 1/0", req_ready, mem_we); end
      #1 rst = 1'b0;
      n_we = 0; n_rsp = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (mem_we) n_we++;
         if (rsp_valid) n_rsp++;
      end
      checks++; if (n_we != 0 || n_rsp != 0) begin failures++; $display("FAIL mid_quiet got we=%0d rsp=%0d exp 0/0", n_we, n_rsp); end
      checks++; if (ram[1] !== ref_mem[1]) begin failures++; $display("FAIL mid_ram got %h exp %h", ram[1], ref_mem[1]); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_idle got %b exp 1", req_ready); end
   endtask

   task automatic test_back_to_back;
      int n_rsp, n_busy;
      logic [31:0] exp_d;
      exp_d = ref_mem[1];
      n_rsp = 0; n_busy = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h4; req_wdata = 32'h0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            n_rsp++;
            checks++; if (rsp_rdata !== exp_d) begin failures++; $display("FAIL b2b_data got %h exp %h", rsp_rdata, exp_d); end
         end
         if (!req_ready) n_busy++;
      end
      req_valid = 1'b0;
      checks++; if (n_rsp != 2 || n_busy != 4) begin failures++; $display("FAIL b2b_spacing got rsp=%0d busy=%0d exp 2/4", n_rsp, n_busy); end
      @(negedge clk);
   endtask

   task automatic test_random;
      logic        we, u, e;
      logic [1:0]  sz;
      logic [31:0] a, wd, exp_d, exp_w;
      int          idx, exp_cyc, exp_wc;
      for (int i = 0; i < 60; i++) begin
         we = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3)); a = 32'($urandom_range(0, 63)); wd = $urandom;
         idx = int'(a / 4);
         e = exp_err(sz, a);
         exp_d = (!we && !e) ? exp_load(ref_mem[idx], sz, u, a) : 32'h0;
         exp_w = exp_store(ref_mem[idx], sz, a, wd);
         if (e) begin exp_cyc = 1; exp_wc = 0; end
         else if (!we) begin exp_cyc = 2; exp_wc = 0; end
         else if (sz == 2'd2) begin exp_cyc = 2; exp_wc = 1; end
         else begin exp_cyc = 3; exp_wc = 2; end
         do_req(we, sz, u, a, wd);
         if (we && !e) ref_mem[idx] = exp_w;
         checks++; if (o_acc_ready !== 1'b1 || o_rsp_cnt != 1) begin failures++; $display("FAIL rnd_hs[%0d] got ready=%b rsp=%0d exp 1/1", i, o_acc_ready, o_rsp_cnt); end
         checks++; if (o_err !== e || o_rsp_cyc != exp_cyc) begin failures++; $display("FAIL rnd_rsp[%0d] got err=%b cyc=%0d exp %b/%0d", i, o_err, o_rsp_cyc, e, exp_cyc); end
         checks++; if (o_rdata !== exp_d || o_held !== exp_d) begin failures++; $display("FAIL rnd_rdata[%0d] got %h held %h exp %h", i, o_rdata, o_held, exp_d); end
         checks++; if (o_we_cyc != exp_wc || o_we_cnt != (exp_wc != 0 ? 1 : 0)) begin failures++; $display("FAIL rnd_we[%0d] got cyc=%0d cnt=%0d exp %0d", i, o_we_cyc, o_we_cnt, exp_wc); end
         if (exp_wc != 0) begin
            checks++; if (o_we_data !== exp_w || o_we_addr !== (a & 32'hFFFF_FFFC)) begin failures++; $display("FAIL rnd_wdata[%0d] got %h@%h exp %h@%h", i, o_we_data, o_we_addr, exp_w, a & 32'hFFFF_FFFC); end
         end
         checks++; if (ram[idx] !== ref_mem[idx]) begin failures++; $display("FAIL rnd_ram[%0d] got %h exp %h", i, ram[idx], ref_mem[idx]); end
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 16; i++) begin
         ram[i] = $urandom;
         ref_mem[i] = ram[i];
      end
      ram[1] = 32'h8877_6655;
      ref_mem[1] = 32'h8877_6655;
      test_reset;
      test_loads;
      test_subword_store;
      test_word_store;
      test_errors;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
